// File: rtl/bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer with ping-pong banks.
// Define BITREV_SOF_EN to add the registered sof output.
module bitrev_reorder #(
  parameter int width = 16,
  parameter int N     = 9
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             en_in,
  input  logic [N-1:0]     cnt_in,
  input  logic [width-1:0] xin_re,
  input  logic [width-1:0] xin_im,
  output logic             en_out,
  output logic [N-1:0]     cnt_out,
  output logic [width-1:0] yout_re,
  output logic [width-1:0] yout_im,
`ifdef BITREV_SOF_EN
  output logic             sof,
`endif
  output logic             ovf
);

  localparam int          DEPTH = 2**N;
  localparam logic [N-1:0] LAST = '1;

  typedef logic [2*width-1:0] word_t;

  typedef enum logic {
    S_IDLE,
    S_READ
  } rd_state_t;

  function automatic logic [N-1:0] bitrev(
    input logic [N-1:0] a
  );
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = a[N-1-i];
    end
    return r;
  endfunction

  rd_state_t    state;
  rd_state_t    state_n;
  logic         wr_bank;
  logic         rd_bank;
  logic         armed;
  logic [N-1:0] rd_cnt;
  logic         rd_active;
  logic         rd_last;
  logic         wr_en;
  logic         fc;
  logic         ovr;

  word_t        mem [2*DEPTH];
  word_t        rd_data;

  logic         s1_vld;
  logic [N-1:0] s1_cnt;

  always_comb begin
    rd_active = (state == S_READ);
    rd_last   = (rd_cnt == LAST);
    wr_en     = areset && en_in &&
                (armed || (cnt_in == '0));
    fc        = areset && en_in && armed &&
                (cnt_in == LAST);
    ovr       = fc && rd_active && !rd_last;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (fc) begin
          state_n = S_READ;
        end
      end
      S_READ: begin
        if (rd_last && !fc) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A completed frame always restarts readout,
  // aborting any readout still in progress.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state   <= S_IDLE;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      armed   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_n;
      if (en_in && (cnt_in == '0)) begin
        armed <= 1'b1;
      end
      if (ovr) begin
        ovf <= 1'b1;
      end
      if (fc) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
        rd_cnt  <= '0;
      end else if (rd_active) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, bitrev(cnt_in)}] <=
        {xin_re, xin_im};
    end
    if (rd_active) begin
      rd_data <= mem[{rd_bank, rd_cnt}];
    end
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      s1_vld  <= 1'b0;
      s1_cnt  <= '0;
      en_out  <= 1'b0;
      cnt_out <= '0;
      yout_re <= '0;
      yout_im <= '0;
    end else begin
      s1_vld <= rd_active;
      s1_cnt <= rd_cnt;
      en_out <= s1_vld;
      if (s1_vld) begin
        cnt_out <= s1_cnt;
        {yout_re, yout_im} <= rd_data;
      end
    end
  end

`ifdef BITREV_SOF_EN
  always_ff @(posedge clk) begin
    if (!areset) begin
      sof <= 1'b0;
    end else begin
      sof <= s1_vld && (s1_cnt == '0);
    end
  end
`endif

endmodule
